// File: rtl/adder_commit_stage_pkg.sv
// Shared constants for the adder commit stage: opcodes, occupancy states, flag bit positions.
package adder_commit_stage_pkg;

  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_ADDS = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/adder_commit_skid.sv
// Generic 2-entry valid/ready skid buffer; outputs come straight from registers.
module adder_commit_skid
  import adder_commit_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

  // Next occupancy and slot contents; flush wins over push, push over pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d  = in_data;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            tail_d  = in_data;
            state_d = OCC_FULL;
          end else if (pop) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy FSM with handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= (state_d != OCC_EMPTY);
      in_ready_q  <= (state_d != OCC_FULL);
    end
  end

endmodule

// File: rtl/adder_commit_stage.sv
// Commit stage behind the adder: buffers results and commits NZCV flags and overflow events on pop.
module adder_commit_stage
  import adder_commit_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_LEN-1:0] in_opcode,
  input  logic [WIDTH-1:0]  in_sum,
  input  logic [4:0]        in_rd,
  input  logic              in_cout,
  input  logic              in_neg,
  input  logic              in_ovf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [4:0]        out_rd,
  output logic [OP_LEN-1:0] out_opcode,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int PW = OP_LEN + 5 + WIDTH + 4;

  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;
  logic [3:0]       head_flags;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             pop;
  logic             is_arith;
  logic             is_signed_op;

  assign in_payload = {in_opcode, in_rd, in_sum, in_neg, in_zero, in_cout, in_ovf};
  assign {out_opcode, out_rd, out_sum, head_flags} = out_payload;
  assign pop       = out_valid & out_ready;
  assign ovf_count = ovf_count_q;

  adder_commit_skid #(
    .W(PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign is_signed_op = (out_opcode == OP_LEN'(OP_ADDS)) || (out_opcode == OP_LEN'(OP_SUB));
  assign is_arith     = is_signed_op || (out_opcode == OP_LEN'(OP_ADDU));

  // Commit of the popped head; a pop alongside flush still commits since the consumer took it.
  always_comb begin
    flags_d     = flags_q;
    ovf_count_d = ovf_count_q;
    if (pop) begin
      if (is_arith) begin
        flags_d = head_flags;
      end
      if (is_signed_op && head_flags[FLAG_V] && (ovf_count_q != '1)) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end
  end

  // Architectural flag register and saturating overflow counter; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= 4'b0000;
      ovf_count_q <= '0;
    end else begin
      flags_q     <= flags_d;
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_adder_commit_stage.sv
// Directed self-checking bench for adder_commit_stage, with a 2-bit counter copy for saturation.
module tb_adder_commit_stage;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_ADDS = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [31:0] in_sum;
  logic [4:0]  in_rd;
  logic        in_cout, in_neg, in_ovf, in_zero;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_sum;
  logic [4:0]  out_rd;
  logic [4:0]  out_opcode;
  logic [3:0]  flags_q;
  logic [15:0] ovf_count;

  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_out_sum;
  logic [4:0]  sat_out_rd;
  logic [4:0]  sat_out_opcode;
  logic [3:0]  sat_flags_q;
  logic [1:0]  sat_ovf_count;

  int compareCount;
  int mismatchCount;

  adder_commit_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_sum(in_sum), .in_rd(in_rd),
    .in_cout(in_cout), .in_neg(in_neg), .in_ovf(in_ovf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_rd(out_rd), .out_opcode(out_opcode),
    .flags_q(flags_q), .ovf_count(ovf_count)
  );

  adder_commit_stage #(.CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_opcode(in_opcode), .in_sum(in_sum), .in_rd(in_rd),
    .in_cout(in_cout), .in_neg(in_neg), .in_ovf(in_ovf), .in_zero(in_zero),
    .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_sum(sat_out_sum), .out_rd(sat_out_rd), .out_opcode(sat_out_opcode),
    .flags_q(sat_flags_q), .ovf_count(sat_ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveEntry(input logic [4:0] op, input logic [31:0] sum, input logic [4:0] rd,
                            input logic n, input logic z, input logic c, input logic v);
    in_valid  = 1'b1;
    in_opcode = op;
    in_sum    = sum;
    in_rd     = rd;
    in_neg    = n;
    in_zero   = z;
    in_cout   = c;
    in_ovf    = v;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] sum, input logic [4:0] rd,
                               input logic n, input logic z, input logic c, input logic v);
    driveEntry(op, sum, rd, n, z, c, v);
    stepCycle();
    in_valid = 1'b0;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_sum    = '0;
    in_rd     = '0;
    in_cout   = 1'b0;
    in_neg    = 1'b0;
    in_ovf    = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    repeat (2) stepCycle();
    rst_n = 1'b1;

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_sum", out_sum, 32'd0);
    checkOutput("rst_flags", 32'(flags_q), 32'd0);
    checkOutput("rst_ovf_count", 32'(ovf_count), 32'd0);

    out_ready = 1'b1;
    applyStimulus(OP_SUB, 32'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_out_sum", out_sum, 32'd0);
    checkOutput("t1_out_rd", 32'(out_rd), 32'd7);
    checkOutput("t1_out_opcode", 32'(out_opcode), 32'(OP_SUB));
    checkOutput("t1_flags_before_pop", 32'(flags_q), 32'd0);
    stepCycle();
    checkOutput("t1_flags_after_pop", 32'(flags_q), 32'b0110);
    checkOutput("t1_empty", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    applyStimulus(OP_SUB, 32'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_ready_one", 32'(in_ready), 32'd1);
    checkOutput("t2_head_one", out_sum, 32'd1);
    applyStimulus(OP_SUB, 32'd2, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_ready_full", 32'(in_ready), 32'd0);
    checkOutput("t2_head_full", out_sum, 32'd1);
    driveEntry(OP_SUB, 32'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    checkOutput("t2_held_sum", out_sum, 32'd1);
    checkOutput("t2_held_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("t2_order_2", out_sum, 32'd2);
    checkOutput("t2_ready_again", 32'(in_ready), 32'd1);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("t2_order_3", out_sum, 32'd3);
    checkOutput("t2_order_3_valid", 32'(out_valid), 32'd1);
    stepCycle();
    checkOutput("t2_drained", 32'(out_valid), 32'd0);
    checkOutput("t2_flags", 32'(flags_q), 32'b0110);

    applyStimulus(OP_ADDS, 32'd10, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADDS, 32'd11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADDU, 32'd12, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checkOutput("t3_ovf_count", 32'(ovf_count), 32'd2);
    checkOutput("t3_sat_count_2", 32'(sat_ovf_count), 32'd2);
    checkOutput("t3_flags_addu", 32'(flags_q), 32'b0001);
    applyStimulus(OP_SUB, 32'd13, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_SUB, 32'd14, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checkOutput("t3_ovf_count_4", 32'(ovf_count), 32'd4);
    checkOutput("t3_sat_stuck", 32'(sat_ovf_count), 32'd3);
    applyStimulus(OP_SUB, 32'd15, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    checkOutput("t3_flags_restore", 32'(flags_q), 32'b0110);

    applyStimulus(OP_NOP, 32'hDEADBEEF, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_nop_sum", out_sum, 32'hDEADBEEF);
    checkOutput("t4_nop_opcode", 32'(out_opcode), 32'(OP_NOP));
    checkOutput("t4_nop_rd", 32'(out_rd), 32'd9);
    stepCycle();
    checkOutput("t4_flags_hold", 32'(flags_q), 32'b0110);
    checkOutput("t4_empty", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    applyStimulus(OP_ADDS, 32'hA, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_ADDS, 32'hB, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_full", 32'(in_ready), 32'd0);
    checkOutput("t5_head", out_sum, 32'hA);
    flush     = 1'b1;
    out_ready = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("t5_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_flush_ready", 32'(in_ready), 32'd1);
    checkOutput("t5_flush_flags", 32'(flags_q), 32'b1000);
    repeat (3) stepCycle();
    checkOutput("t5_no_ghost", 32'(out_valid), 32'd0);
    checkOutput("t5_count_kept", 32'(ovf_count), 32'd4);
    checkOutput("t5_flags_kept", 32'(flags_q), 32'b1000);

    out_ready = 1'b0;
    applyStimulus(OP_SUB, 32'h55, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_one_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_async_ready", 32'(in_ready), 32'd1);
    checkOutput("t6_async_flags", 32'(flags_q), 32'd0);
    checkOutput("t6_async_count", 32'(ovf_count), 32'd0);
    checkOutput("t6_async_sat_count", 32'(sat_ovf_count), 32'd0);
    checkOutput("t6_async_sum", out_sum, 32'd0);
    stepCycle();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
